mux2_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for a 2:1 data selector shared by two requesters.
//  It registers the grant, drives the selector's sel and caps tenure under contention.
//  It then registers the selected data with a valid flag for the downstream consumer.
//  It sits between two producer blocks and the single shared output path.

---
 rtl/mux2_arbiter_pkg.sv | 22 ++
 rtl/mux2_arbiter_mux2_w.sv | 21 ++
 rtl/mux2_arbiter.sv | 137 +++++++++++++
 tb/tb_mux2_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter and its selector.
package mux2_arbiter_pkg;

  // Arbiter state; the grant outputs are one-hot decodes of the two grant states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  // Selector control encodings.
  localparam logic SEL_IN0 = 1'b0;
  localparam logic SEL_IN1 = 1'b1;

  // Requester index owning a grant state (IDLE maps to requester 0, only used for sel/last hold).
  function automatic logic owner_of(input arb_state_t st);
    logic owner;
    owner = (st == ST_GNT1) ? SEL_IN1 : SEL_IN0;
    return owner;
  endfunction

endpackage

// File: rtl/mux2_arbiter_mux2_w.sv
// Parameterised DATA_W-wide 2:1 combinational selector.
module mux2_w #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out
);

  // Pure select: 0 picks in0, 1 picks in1.
  always_comb begin
    out = {DATA_W{1'b0}};
    if (sel) begin
      out = in1;
    end else begin
      out = in0;
    end
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for a shared 2:1 data path: registered grants and sel,
// tenure cap under contention, and a registered output word with valid flag.
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] next_hold;
  logic              last_gnt;
  logic              next_last;
  logic              next_sel;
  logic              next_valid;
  logic              entering;
  logic [DATA_W-1:0] mux_out;

  mux2_w #(.DATA_W(DATA_W)) u_mux (
    .sel (sel),
    .in0 (in_data0),
    .in1 (in_data1),
    .out (mux_out)
  );

  // Next-state: round-robin tie break from IDLE, handoff without bubble, tenure preemption.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          next_state = last_gnt ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          next_state = ST_GNT0;
        end else if (req1) begin
          next_state = ST_GNT1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_GNT0: begin
        if (!req0) begin
          next_state = req1 ? ST_GNT1 : ST_IDLE;
        end else if (req1 && (hold_cnt == HOLD_LAST)) begin
          next_state = ST_GNT1;
        end else begin
          next_state = ST_GNT0;
        end
      end
      ST_GNT1: begin
        if (!req1) begin
          next_state = req0 ? ST_GNT0 : ST_IDLE;
        end else if (req0 && (hold_cnt == HOLD_LAST)) begin
          next_state = ST_GNT0;
        end else begin
          next_state = ST_GNT1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Companion next values: tenure counter, round-robin memory, sel and output valid.
  always_comb begin
    entering   = (next_state != state) && (next_state != ST_IDLE);
    next_hold  = {HOLD_W{1'b0}};
    next_last  = last_gnt;
    next_sel   = sel;
    next_valid = (gnt0 && req0) || (gnt1 && req1);
    if (next_state == ST_IDLE) begin
      // sel and last_gnt keep their values while nobody owns the path.
      next_hold = {HOLD_W{1'b0}};
    end else if (entering) begin
      next_hold = {HOLD_W{1'b0}};
      next_last = owner_of(next_state);
      next_sel  = owner_of(next_state);
    end else if (hold_cnt == HOLD_LAST) begin
      next_hold = hold_cnt;
    end else begin
      next_hold = hold_cnt + HOLD_W'(1);
    end
  end

  // State, grant, sel and tenure registers; reset leaves requester 0 winning the first tie.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= {HOLD_W{1'b0}};
      last_gnt <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      sel      <= SEL_IN0;
    end else begin
      state    <= next_state;
      hold_cnt <= next_hold;
      last_gnt <= next_last;
      gnt0     <= (next_state == ST_GNT0);
      gnt1     <= (next_state == ST_GNT1);
      sel      <= next_sel;
    end
  end

  // Output word register: captures only words from an owner still requesting, otherwise holds.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_data  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      out_valid <= next_valid;
      if (next_valid) begin
        out_data <= mux_out;
      end else begin
        out_data <= out_data;
      end
    end
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench: two DUTs (MAX_HOLD=4 and MAX_HOLD=1) share stimulus and
// are compared every cycle against a tenure-counting behavioural model.
module tb_mux2_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0;
  logic       req1;
  logic [7:0] in0;
  logic [7:0] in1;
  logic       chk_en;

  wire        a_gnt0, a_gnt1, a_sel, a_valid;
  wire  [7:0] a_data;
  wire        b_gnt0, b_gnt1, b_sel, b_valid;
  wire  [7:0] b_data;

  int n_cmp;
  int n_bad;

  typedef struct {
    int         owner;   // -1 none, 0 or 1
    int         run;     // cycles the current owner has visibly held the grant
    int         last;
    logic       sel;
    logic [7:0] data;
    logic       valid;
  } mst_t;

  mst_t m [2];

  mux2_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .req0(req0), .req1(req1),
    .in_data0(in0), .in_data1(in1), .gnt0(a_gnt0), .gnt1(a_gnt1),
    .sel(a_sel), .out_data(a_data), .out_valid(a_valid)
  );

  mux2_arbiter #(.DATA_W(8), .MAX_HOLD(1)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .req0(req0), .req1(req1),
    .in_data0(in0), .in_data1(in1), .gnt0(b_gnt0), .gnt1(b_gnt1),
    .sel(b_sel), .out_data(b_data), .out_valid(b_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mst_t reset_state();
    mst_t s;
    s.owner = -1; s.run = 0; s.last = 1; s.sel = 1'b0; s.data = 8'h00; s.valid = 1'b0;
    return s;
  endfunction

  // One clock of the arbiter rules, phrased as owner/tenure bookkeeping.
  function automatic mst_t step(input mst_t s, input int lim, input logic r0, input logic r1,
                                input logic [7:0] d0, input logic [7:0] d1);
    mst_t n;
    int   nw;
    logic mine;
    logic other;
    n = s;
    n.valid = (s.owner == 0 && r0) || (s.owner == 1 && r1);
    if (n.valid) n.data = s.sel ? d1 : d0;
    if (s.owner < 0) begin
      if (r0 && r1) nw = 1 - s.last;
      else if (r0)  nw = 0;
      else if (r1)  nw = 1;
      else          nw = -1;
    end else begin
      mine  = (s.owner == 0) ? r0 : r1;
      other = (s.owner == 0) ? r1 : r0;
      if (!mine)                    nw = other ? 1 - s.owner : -1;
      else if (other && s.run >= lim) nw = 1 - s.owner;
      else                          nw = s.owner;
    end
    if (nw < 0) begin
      n.owner = -1; n.run = 0;
    end else if (nw != s.owner) begin
      n.owner = nw; n.run = 1; n.last = nw; n.sel = (nw == 1);
    end else begin
      n.run = s.run + 1;
    end
    return n;
  endfunction

  // Reference model update, reset asynchronously like the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= reset_state();
      m[1] <= reset_state();
    end else begin
      m[0] <= step(m[0], 4, req0, req1, in0, in1);
      m[1] <= step(m[1], 1, req0, req1, in0, in1);
    end
  end

  task automatic cmp_dut(input string tag, input logic g0, input logic g1, input logic s,
                         input logic v, input logic [7:0] d, input mst_t e);
    chk({tag, "_gnt0"}, int'(g0), int'(e.owner == 0));
    chk({tag, "_gnt1"}, int'(g1), int'(e.owner == 1));
    chk({tag, "_sel"},  int'(s),  int'(e.sel));
    chk({tag, "_valid"}, int'(v), int'(e.valid));
    chk({tag, "_data"}, int'(d),  int'(e.data));
    chk({tag, "_mutex"}, int'(g0 & g1), 0);
  endtask

  // Every-cycle comparison away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("h4", a_gnt0, a_gnt1, a_sel, a_valid, a_data, m[0]);
      cmp_dut("h1", b_gnt0, b_gnt1, b_sel, b_valid, b_data, m[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; in0 = 8'h00; in1 = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt0", int'(a_gnt0), 0);
    chk("rst_gnt1", int'(a_gnt1), 0);
    chk("rst_sel", int'(a_sel), 0);
    chk("rst_valid", int'(a_valid), 0);
    chk("rst_data", int'(a_data), 0);
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester: grant after one edge, data after two.
    req0 = 1'b1; in0 = 8'hA5;
    tick();
    chk("s1_gnt0", int'(a_gnt0), 1);
    chk("s1_sel", int'(a_sel), 0);
    chk("s1_valid_early", int'(a_valid), 0);
    chk("s1_model_owner", m[0].owner, 0);
    tick();
    chk("s1_data", int'(a_data), 8'hA5);
    chk("s1_valid", int'(a_valid), 1);

    // Owner drops while the other requests: direct handoff.
    req0 = 1'b0; req1 = 1'b1; in1 = 8'h3C;
    tick();
    chk("s3_gnt1", int'(a_gnt1), 1);
    chk("s3_gnt0", int'(a_gnt0), 0);
    chk("s3_sel", int'(a_sel), 1);
    tick();
    chk("s3_data", int'(a_data), 8'h3C);
    chk("s3_valid", int'(a_valid), 1);

    // Sole requester is never preempted.
    for (int i = 0; i < 10; i++) begin
      chk("s4_hold", int'(a_gnt1), 1);
      tick();
    end
    req1 = 1'b0; in1 = 8'h77;
    tick();
    chk("s4_idle_gnt1", int'(a_gnt1), 0);
    chk("s4_idle_valid", int'(a_valid), 0);
    chk("s4_data_hold", int'(a_data), 8'h3C);
    chk("s4_sel_hold", int'(a_sel), 1);

    // Asynchronous reset in the middle of a grant.
    req1 = 1'b1;
    tick();
    tick();
    chk("s5_pre_gnt1", int'(a_gnt1), 1);
    rst_n = 1'b0;
    #1;
    chk("s5_async_gnt1", int'(a_gnt1), 0);
    chk("s5_async_sel", int'(a_sel), 0);
    chk("s5_async_valid", int'(a_valid), 0);
    chk("s5_async_data", int'(a_data), 0);
    req0 = 1'b1; req1 = 1'b1; in0 = 8'h11; in1 = 8'h22;
    #2 rst_n = 1'b1;

    // Permanent contention: 4/4 rotation on one DUT, per-cycle alternation on the other.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("s2_h4_gnt0", int'(a_gnt0), int'((i % 8) < 4));
      chk("s2_h4_gnt1", int'(a_gnt1), int'((i % 8) >= 4));
      chk("s6_h1_gnt0", int'(b_gnt0), int'((i % 2) == 0));
      if (i >= 1) chk("s6_h1_data", int'(b_data), (i % 2 == 1) ? 8'h11 : 8'h22);
    end

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) req0 = ~req0;
      if ($urandom_range(0, 5) == 0) req1 = ~req1;
      in0 = 8'($urandom);
      in1 = 8'($urandom);
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
